ecc_syn_sched: RTL and testbench

- Two-requester scheduler that time-shares the single combinational H-matrix syndrome unit (8/16/32-bit SECDED) between two codeword sources.
- Arbitrates round-robin and holds the selected codeword stable at the unit's inputs.
- Registers the returned 6-bit syndrome and classifies it as 0, 1 or 2 errors.
- Delivers the result through a valid/ready response port and keeps saturating error-statistics counters.

---
 rtl/ecc_syn_sched.sv | 188 ++++++++++++++++++
 tb/tb_ecc_syn_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_syn_sched.sv
// Round-robin scheduler that time-shares one combinational SECDED syndrome unit
// between two codeword requesters, with a valid/ready response port and error statistics.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for a request; grants one requester combinationally
//   CALC  | latched codeword at the unit; capture and classify the syndrome
//   RESP  | response valid; held until the consumer accepts it
module ecc_syn_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic [1:0]            req0_width,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic [1:0]            req1_width,
    output logic [DATA_WIDTH-1:0] syn_codeword,
    output logic [1:0]            syn_width,
    input  logic [5:0]            syn_column,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [5:0]            rsp_syndrome,
    output logic [1:0]            rsp_num_err,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  err1_cnt,
    output logic [CNT_WIDTH-1:0]  err2_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state;
    state_t                  state_nxt;
    logic                    rr;
    logic                    id_q;
    logic [1:0]              width_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [5:0]              syn_q;
    logic [1:0]              num_err_q;
    logic [CNT_WIDTH-1:0]    err1_q;
    logic [CNT_WIDTH-1:0]    err2_q;

    logic                    grant;
    logic                    grant_id;
    logic [1:0]              grant_width;
    logic [DATA_WIDTH-1:0]   grant_data;
    logic [DATA_WIDTH-1:0]   grant_mask;
    logic                    parity_bit;
    logic [4:0]              pos_field;
    logic [1:0]              num_err_calc;

    // Contention goes to rr; a lone requester wins regardless of rr.
    always_comb begin
        grant_id    = (req0_valid && req1_valid) ? rr : req1_valid;
        grant_width = grant_id ? req1_width : req0_width;
        grant_data  = grant_id ? req1_data : req0_data;
        grant_mask  = {DATA_WIDTH{1'b1}};
        case (grant_width)
            2'd0:    grant_mask = {{(DATA_WIDTH-8){1'b0}}, {8{1'b1}}};
            2'd1:    grant_mask = {{(DATA_WIDTH-16){1'b0}}, {16{1'b1}}};
            default: grant_mask = {DATA_WIDTH{1'b1}};
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The overall-parity bit moves with the codeword size; the position field sits below it.
    always_comb begin
        parity_bit = syn_column[5];
        pos_field  = syn_column[4:0];
        case (width_q)
            2'd0: begin
                parity_bit = syn_column[3];
                pos_field  = {2'b00, syn_column[2:0]};
            end
            2'd1: begin
                parity_bit = syn_column[4];
                pos_field  = {1'b0, syn_column[3:0]};
            end
            default: begin
                parity_bit = syn_column[5];
                pos_field  = syn_column[4:0];
            end
        endcase
        if (syn_column == 6'd0) begin
            num_err_calc = 2'd0;
        end else if (parity_bit) begin
            num_err_calc = 2'd1;
        end else if (pos_field != 5'd0) begin
            num_err_calc = 2'd2;
        end else begin
            num_err_calc = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= 1'b0;
            id_q      <= 1'b0;
            width_q   <= 2'd0;
            data_q    <= '0;
            syn_q     <= 6'd0;
            num_err_q <= 2'd0;
        end else begin
            if (grant) begin
                id_q    <= grant_id;
                width_q <= grant_width;
                data_q  <= grant_data & grant_mask;
                rr      <= ~grant_id;
            end
            if (state == CALC) begin
                syn_q     <= syn_column;
                num_err_q <= num_err_calc;
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err1_q <= '0;
            err2_q <= '0;
        end else if (cnt_clr) begin
            err1_q <= '0;
            err2_q <= '0;
        end else if (state == CALC) begin
            if (num_err_calc == 2'd1 && err1_q != CNT_MAX) begin
                err1_q <= err1_q + CNT_ONE;
            end
            if (num_err_calc == 2'd2 && err2_q != CNT_MAX) begin
                err2_q <= err2_q + CNT_ONE;
            end
        end
    end

    assign req0_ready   = grant & ~grant_id & rst;
    assign req1_ready   = grant & grant_id & rst;
    assign syn_codeword = data_q;
    assign syn_width    = width_q;
    assign rsp_valid    = (state == RESP);
    assign rsp_id       = id_q;
    assign rsp_data     = data_q;
    assign rsp_syndrome = syn_q;
    assign rsp_num_err  = num_err_q;
    assign err1_cnt     = err1_q;
    assign err2_cnt     = err2_q;

endmodule

// File: tb/tb_ecc_syn_sched.sv
// Bench for ecc_syn_sched: a Hamming-style syndrome unit model feeds the DUT, and a
// transaction-level reference predicts grants, responses and counter values.
module tb_ecc_syn_sched;

    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [31:0]   d0 = '0, d1 = '0;
    logic [1:0]    w0 = '0, w1 = '0;
    logic          rsp_ready = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [5:0]    syn_column;

    logic          req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0]   syn_codeword, rsp_data;
    logic [1:0]    syn_width, rsp_num_err;
    logic [5:0]    rsp_syndrome;
    logic [CW-1:0] err1_cnt, err2_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference state
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_rr   = 0;
    bit          m_id   = 0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_w    = '0;
    logic [5:0]  m_syn  = '0;
    int          m_nerr = 0;
    int          m_c1   = 0;
    int          m_c2   = 0;

    // last observation
    bit          o_r0, o_r1, o_rv, o_id;
    logic [31:0] o_data, o_e1, o_e2;
    logic [5:0]  o_syn;
    logic [1:0]  o_ne;
    int          o_cyc;

    // captured response of run_one
    bit          r_id;
    logic [31:0] r_data, r_e1, r_e2;
    logic [5:0]  r_syn;
    logic [1:0]  r_ne;

    ecc_syn_sched #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_data(d0), .req0_width(w0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_data(d1), .req1_width(w1),
        .syn_codeword(syn_codeword), .syn_width(syn_width), .syn_column(syn_column),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_syndrome(rsp_syndrome), .rsp_num_err(rsp_num_err),
        .cnt_clr(cnt_clr), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt)
    );

    always #5 clk = ~clk;

    function automatic int wbits(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endfunction

    function automatic int wlog(input logic [1:0] w);
        return (w == 2'd0) ? 3 : (w == 2'd1) ? 4 : 5;
    endfunction

    // Position i+1 for bit i below the top bit; the top bit is the overall parity.
    function automatic logic [5:0] unit_syn(input logic [31:0] cw, input logic [1:0] w);
        int n   = wbits(w);
        int pos = 0;
        int par = 0;
        for (int i = 0; i < 32; i++) begin
            if (cw[i]) begin
                par ^= 1;
                if (i < n - 1) pos ^= (i + 1);
            end
        end
        return 6'((par << wlog(w)) | pos);
    endfunction

    function automatic logic [31:0] mask_w(input logic [31:0] d, input logic [1:0] w);
        int n = wbits(w);
        if (n == 32) return d;
        return d & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic int classify(input logic [5:0] s, input logic [1:0] w);
        if (s == 6'd0) return 0;
        return s[wlog(w)] ? 1 : 2;
    endfunction

    // clean, single-bit, double-bit or random word in the active field, junk above it
    function automatic logic [31:0] gen_word(input logic [1:0] w);
        int          n    = wbits(w);
        int          kind = $urandom_range(0, 3);
        int          i    = $urandom_range(0, n - 1);
        int          j    = (i + 1 + $urandom_range(0, n - 2)) % n;
        logic [31:0] low  = '0;
        logic [31:0] junk = $urandom;
        case (kind)
            0:       low = '0;
            1:       low = 32'd1 << i;
            2:       low = (32'd1 << i) | (32'd1 << j);
            default: low = $urandom;
        endcase
        return (junk & ~mask_w(32'hFFFF_FFFF, w)) | mask_w(low, w);
    endfunction

    always_comb syn_column = unit_syn(syn_codeword, syn_width);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        bit g_any;
        bit g_id;
        #1;
        g_any  = !m_busy && (v0 || v1);
        g_id   = (v0 && v1) ? m_rr : v1;
        o_r0   = req0_ready;
        o_r1   = req1_ready;
        o_rv   = rsp_valid;
        o_id   = rsp_id;
        o_data = rsp_data;
        o_syn  = rsp_syndrome;
        o_ne   = rsp_num_err;
        o_e1   = 32'(err1_cnt);
        o_e2   = 32'(err2_cnt);
        o_cyc  = cyc;
        check_val("req0_ready", req0_ready, g_any && !g_id);
        check_val("req1_ready", req1_ready, g_any && g_id);
        check_val("rsp_valid", rsp_valid, m_busy && m_age >= 1);
        if (m_busy) begin
            check_val("syn_codeword", syn_codeword, m_data);
            check_val("syn_width", syn_width, m_w);
        end
        if (m_busy && m_age >= 1) begin
            check_val("rsp_id", rsp_id, m_id);
            check_val("rsp_data", rsp_data, m_data);
            check_val("rsp_syndrome", rsp_syndrome, m_syn);
            check_val("rsp_num_err", rsp_num_err, m_nerr);
        end
        check_val("err1_cnt", o_e1, m_c1);
        check_val("err2_cnt", o_e2, m_c2);

        if (cnt_clr) begin
            m_c1 = 0;
            m_c2 = 0;
        end else if (m_busy && m_age == 0) begin
            if (m_nerr == 1 && m_c1 < CMAX) m_c1++;
            if (m_nerr == 2 && m_c2 < CMAX) m_c2++;
        end
        if (m_busy) begin
            if (m_age >= 1 && rsp_ready) m_busy = 0;
            else m_age++;
        end else if (g_any) begin
            m_busy = 1;
            m_age  = 0;
            m_id   = g_id;
            m_w    = g_id ? w1 : w0;
            m_data = mask_w(g_id ? d1 : d0, m_w);
            m_syn  = unit_syn(m_data, m_w);
            m_nerr = classify(m_syn, m_w);
            m_rr   = !g_id;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check_val("rst_req0_ready", req0_ready, 0);
        check_val("rst_req1_ready", req1_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_syn_codeword", syn_codeword, 0);
        check_val("rst_syn_width", syn_width, 0);
        check_val("rst_rsp_id", rsp_id, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_syndrome", rsp_syndrome, 0);
        check_val("rst_rsp_num_err", rsp_num_err, 0);
        check_val("rst_err1_cnt", 32'(err1_cnt), 0);
        check_val("rst_err2_cnt", 32'(err2_cnt), 0);
        m_busy = 0; m_age = 0; m_rr = 0; m_c1 = 0; m_c2 = 0;
        @(negedge clk);
        v0  = 1'b0;
        v1  = 1'b0;
        rst = 1'b1;
    endtask

    // Single transaction on an idle DUT with rsp_ready high; captures the response.
    task automatic run_one(input bit id, input logic [1:0] w, input logic [31:0] d);
        bit got = 0;
        int gc  = 0;
        rsp_ready = 1'b1;
        if (id) begin v1 = 1'b1; w1 = w; d1 = d; end
        else    begin v0 = 1'b1; w0 = w; d0 = d; end
        for (int k = 0; k < 4 && !got; k++) begin
            step();
            if (id ? o_r1 : o_r0) begin got = 1; gc = o_cyc; end
        end
        if (!got) check_val("grant_timeout", 0, 1);
        v0 = 1'b0;
        v1 = 1'b0;
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (o_rv) begin
                got = 1;
                r_id = o_id; r_data = o_data; r_syn = o_syn; r_ne = o_ne;
                r_e1 = o_e1; r_e2 = o_e2;
                check_val("latency", o_cyc - gc, 2);
            end
        end
        if (!got) check_val("rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        cnt_clr = 1'b0;
        for (int k = 0; k < 8 && m_busy; k++) step();
        if (m_busy) check_val("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[4];
        int gcy[4];
        int ng;
        int bp_rdy;
        bit got;

        @(negedge clk);
        apply_reset();

        run_one(0, 2'd0, 32'h0000_0001);
        check_val("t1_id", r_id, 0);
        check_val("t1_syndrome", r_syn, 6'h09);
        check_val("t1_num_err", r_ne, 1);
        check_val("t1_err1", r_e1, 1);

        run_one(1, 2'd2, 32'h0000_0000);
        check_val("t2_id", r_id, 1);
        check_val("t2_syndrome", r_syn, 6'h00);
        check_val("t2_num_err", r_ne, 0);
        check_val("t2_err1", r_e1, 1);
        check_val("t2_err2", r_e2, 0);

        run_one(0, 2'd1, 32'hFFFF_0003);
        check_val("t3_data", r_data, 32'h0000_0003);
        check_val("t3_syndrome", r_syn, 6'h03);
        check_val("t3_num_err", r_ne, 2);
        check_val("t3_err2", r_e2, 1);

        // clear in the same cycle as a single-error increment
        rsp_ready = 1'b1;
        v0 = 1'b1; w0 = 2'd0; d0 = 32'h0000_0001;
        step();
        check_val("clr_grant", o_r0, 1);
        v0 = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        check_val("clr_err1", o_e1, 0);
        check_val("clr_err2", o_e2, 0);
        drain();

        // round robin under continuous contention
        apply_reset();
        v0 = 1'b1; w0 = 2'd0; d0 = 32'h0000_0001;
        v1 = 1'b1; w1 = 2'd2; d1 = 32'h0000_0000;
        rsp_ready = 1'b1;
        ng = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            if ((o_r0 || o_r1) && ng < 4) begin
                gid[ng] = o_r1;
                gcy[ng] = o_cyc;
                ng++;
            end
        end
        check_val("rr_grant_count", ng, 4);
        for (int k = 0; k < ng; k++) begin
            check_val("rr_grant_id", gid[k], k % 2);
            check_val("rr_interval", gcy[k] - gcy[0], 3 * k);
        end
        drain();

        // back-pressure with a second requester waiting
        rsp_ready = 1'b0;
        v0 = 1'b1; w0 = 2'd2; d0 = $urandom;
        v1 = 1'b1; w1 = 2'd1; d1 = $urandom;
        step();
        check_val("bp_grant", o_r0 || o_r1, 1);
        if (o_r0) v0 = 1'b0;
        if (o_r1) v1 = 1'b0;
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            step();
            got = o_rv;
        end
        check_val("bp_rsp_valid", got, 1);
        bp_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            bp_rdy += (o_r0 || o_r1) ? 1 : 0;
            check_val("bp_hold_valid", o_rv, 1);
        end
        check_val("bp_no_ready", bp_rdy, 0);
        rsp_ready = 1'b1;
        step();
        step();
        check_val("bp_next_grant", o_r0 || o_r1, 1);
        if (o_r0) v0 = 1'b0;
        if (o_r1) v1 = 1'b0;
        drain();

        // randomized traffic against the reference
        for (int c = 0; c < 600; c++) begin
            if (!v0 || o_r0) begin
                v0 = ($urandom_range(0, 2) != 0);
                w0 = 2'($urandom_range(0, 3));
                d0 = gen_word(w0);
            end
            if (!v1 || o_r1) begin
                v1 = ($urandom_range(0, 2) != 0);
                w1 = 2'($urandom_range(0, 3));
                d1 = gen_word(w1);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            step();
        end
        drain();

        // reset while the syndrome is being captured
        run_one(0, 2'd0, 32'h0000_0001);
        rsp_ready = 1'b1;
        v0 = 1'b1; w0 = 2'd0; d0 = 32'h0000_0001;
        step();
        check_val("rstcalc_grant", o_r0, 1);
        apply_reset();
        got = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            got |= o_rv;
        end
        check_val("rstcalc_no_rsp", got, 0);

        // saturation of the single-error counter
        for (int k = 0; k < CMAX + 2; k++) run_one(k % 2, 2'd0, 32'h0000_0001);
        check_val("sat_err1", r_e1, CMAX);
        check_val("sat_err2", r_e2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
